rom_stream_reader: RTL and testbench

- Sequencer that sits directly upstream of the team's combinational `rom` block (E, addr[3:0] → data[7:0]) and consumes its output.
- On a start command it walks a run of consecutive ROM addresses and drives E/addr itself.
- Each returned byte is captured into a 2-entry output FIFO and presented on a valid/ready stream.
- Signals completion with a one-cycle done pulse and keeps a running 8-bit checksum of the delivered bytes.

---
 rtl/rom_stream_reader.sv | 118 +++++++++++
 tb/tb_rom_stream_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Sequencer that walks a run of consecutive ROM addresses, buffers each
// returned byte in a 2-entry FIFO and streams it out with a running checksum.
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rom_E,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W:0]     remaining;

  logic [DATA_W-1:0]   mem [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;

  logic                pop;
  logic                push;
  logic                space;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A full FIFO still has room when its head leaves in the same cycle.
  assign space     = (count < 2'd2) || pop;
  assign push      = (state == FETCH) && space;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    rom_E    = 1'b0;
    rom_addr = '0;
    if (push) begin
      rom_E    = 1'b1;
      rom_addr = cur_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      checksum  <= '0;
    end else begin
      if (pop) checksum <= checksum + out_data;
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= len;
            checksum  <= '0;
            state     <= (len == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (push) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && count == 2'd1) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the two storage entries are reset because out_data must read 0
  // out of reset; a deeper buffer would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rom_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: table-driven runs, a reset abort
// sequence and randomized back-pressure runs against a queue-based model.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic       busy, done, rom_E;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Combinational ROM model: mem[a] = 0x10 + a.
  assign rom_data = rom_E ? (8'h10 + {4'b0, rom_addr}) : 8'h00;

  rom_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_E      (rom_E),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .checksum   (checksum)
  );

  // mode: 0 = ready always high, 1 = random ready, 2 = ready low for 'hold' cycles
  typedef struct {
    logic [3:0] sa;
    logic [4:0] ln;
    int         mode;
    int         hold;
    int         abort_after;
    int         restart_cyc;
    int         exp_done;
    int         exp_sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_at(input vec_t v, input int c);
    case (v.mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return (c >= v.hold);
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_rom_E"},     rom_E,     0);
    check({tag, "_rom_addr"},  rom_addr,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_checksum"},  checksum,  0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] exp_q [$];
    logic [7:0] b;
    logic [7:0] sum;
    logic [7:0] exp_chk;
    int nb, nf, c;
    bit fin;
    sum = 8'h00;
    for (int i = 0; i < int'(v.ln); i++) begin
      b = 8'h10 + 8'((int'(v.sa) + i) % 16);
      exp_q.push_back(b);
      sum = sum + b;
    end
    exp_chk = (v.exp_sum >= 0) ? 8'(v.exp_sum) : sum;

    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = v.sa;
    len        = v.ln;
    out_ready  = ready_at(v, 0);
    nb = 0; nf = 0; fin = 1'b0;

    for (c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) check("busy_before_start", busy, 0);
      else        check("busy_during_run", busy, 1);

      if (rom_E) begin
        check("fetch_addr", rom_addr, 32'((int'(v.sa) + nf) % 16));
        check("fetch_count_in_range", nf < int'(v.ln), 1);
        nf++;
      end else begin
        check("rom_addr_zero_when_idle", rom_addr, 0);
      end

      if (out_valid) begin
        if (nb < exp_q.size()) check("out_data", out_data, exp_q[nb]);
        else                   check("extra_byte", nb, v.ln);
        if (out_ready) nb++;
      end

      if (v.mode == 0 && v.ln != 0 && c == 1) begin
        check("first_fetch_latency", rom_E, 1);
        check("valid_not_yet", out_valid, 0);
      end
      if (v.mode == 0 && v.ln != 0 && c == 2) check("valid_latency", out_valid, 1);
      if (v.mode == 2 && c == v.hold - 1) begin
        check("stall_fetch_count", nf, 2);
        check("stall_rom_E", rom_E, 0);
        check("stall_head", out_data, exp_q[0]);
      end
      if (v.ln == 0 && c > 0) check("len0_quiet", {rom_E, out_valid}, 0);

      if (v.abort_after > 0 && nb == v.abort_after) begin
        check("no_done_before_abort", done, 0);
        fin = 1'b1;
      end else if (done) begin
        check("done_byte_count", nb, v.ln);
        check("done_checksum", checksum, exp_chk);
        if (v.exp_done >= 0) check("done_cycle", c, v.exp_done);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("checksum_holds", checksum, exp_chk);
        fin = 1'b1;
      end

      if (!fin) begin
        @(posedge clk); #1;
        start = (c + 1 == v.restart_cyc);
        if (start) begin
          start_addr = 4'd9;
          len        = 5'd2;
        end
        out_ready = ready_at(v, c + 1);
      end
    end
    start = 1'b0;
    if (!fin) check("run_timeout", 0, 1);
  endtask

  vec_t vecs [7];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b0;

    //            sa     ln     mode hold abort restart done  sum
    vecs[0] = '{4'd0,  5'd5,  0,   0,   0,    -1,     7,    'h5A};
    vecs[1] = '{4'd14, 5'd4,  0,   0,   0,    -1,     6,    'h5E};
    vecs[2] = '{4'd0,  5'd4,  2,   6,   0,    -1,     -1,   'h46};
    vecs[3] = '{4'd5,  5'd0,  0,   0,   0,    -1,     1,    'h00};
    vecs[4] = '{4'd7,  5'd16, 0,   0,   0,    -1,     18,   'h78};
    vecs[5] = '{4'd3,  5'd16, 0,   0,   6,    3,      -1,   -1};
    vecs[6] = '{4'd2,  5'd3,  0,   0,   0,    -1,     5,    'h39};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_all_zero("idle");
    end

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (vecs[i].abort_after > 0) begin
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_abort");
      end
    end

    for (int k = 0; k < 25; k++) begin
      rv = '{4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)), 1, 0, 0, -1, -1, -1};
      run_vec(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
